// File: rtl/spi_slave_core.sv
// SPI responder core: oversamples SCLK/MOSI/SS_n in the clk domain, modes 0-3, MSB-first W-bit frames.
// One-entry TX holding buffer and one-entry RX holding register with sticky underrun/overrun flags.
`timescale 1ns/1ps
module spi_slave_core #(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpol,
  input  logic         cpha,
  input  logic         tx_wr,
  input  logic [W-1:0] tx_data,
  output logic         tx_full,
  input  logic         rx_rd,
  output logic [W-1:0] rx_data,
  output logic         rx_avail,
  input  logic         clr_err,
  output logic         rx_overrun,
  output logic         tx_underrun,
  output logic         busy,
  input  logic         spi_sclk,
  input  logic         spi_mosi,
  input  logic         spi_ss_n,
  output logic         spi_miso,
  output logic         spi_miso_oe
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [SYNC-1:0] sclk_sync, mosi_sync, ss_sync;
  logic            sclk_d, ss_d;
  logic            cpol_l, cpha_l, pending_load;
  logic [CW-1:0]   bit_cnt;
  logic [W-1:0]    rx_sr, tx_sr, tx_buf;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, frame_done, tx_load;

  // NOTE: every register in a clocked block is updated with <=, so all reads see the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC-2:0], spi_ss_n};
      sclk_d    <= sclk_sync[SYNC-1];
      ss_d      <= ss_sync[SYNC-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC-1];
  assign mosi_s = mosi_sync[SYNC-1];
  assign ss_s   = ss_sync[SYNC-1];

  // Leading edge leaves the latched idle level, trailing edge returns to it.
  assign sclk_edge   = sclk_s ^ sclk_d;
  assign lead_edge   = sclk_edge & (sclk_d == cpol_l);
  assign trail_edge  = sclk_edge & (sclk_s == cpol_l);
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge : trail_edge;
  assign ss_fall     = ss_d & ~ss_s;

  assign frame_done = (state == ACTIVE) && !ss_s && sample_edge && (bit_cnt == CW'(W - 1));
  assign tx_load    = ((state == IDLE) && ss_fall && !cpha) ||
                      ((state == ACTIVE) && !ss_s && shift_edge && pending_load);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cpol_l       <= 1'b0;
      cpha_l       <= 1'b0;
      pending_load <= 1'b0;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '1;
      tx_buf       <= '0;
      tx_full      <= 1'b0;
      rx_data      <= '0;
      rx_avail     <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      // Clears come first so a coincident error event below takes precedence.
      if (clr_err) begin
        rx_overrun  <= 1'b0;
        tx_underrun <= 1'b0;
      end
      if (rx_rd)
        rx_avail <= 1'b0;

      // A write is accepted into a full buffer only when a load empties it in the same cycle.
      if (tx_wr && (!tx_full || tx_load))
        tx_buf <= tx_data;
      if (tx_load) begin
        if (tx_full) begin
          tx_sr <= tx_buf;
        end else begin
          tx_sr       <= '1;
          tx_underrun <= 1'b1;
        end
      end
      if (tx_load && tx_full && !tx_wr)
        tx_full <= 1'b0;
      else if (tx_wr)
        tx_full <= 1'b1;

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state        <= ACTIVE;
            busy         <= 1'b1;
            cpol_l       <= cpol;
            cpha_l       <= cpha;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            pending_load <= cpha;
          end
        end
        ACTIVE: begin
          if (ss_s) begin
            state        <= IDLE;
            busy         <= 1'b0;
            pending_load <= 1'b0;
          end else if (sample_edge) begin
            rx_sr <= {rx_sr[W-2:0], mosi_s};
            if (frame_done) begin
              bit_cnt      <= '0;
              rx_data      <= {rx_sr[W-2:0], mosi_s};
              rx_avail     <= 1'b1;
              pending_load <= 1'b1;
              if (rx_avail && !rx_rd)
                rx_overrun <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge) begin
            if (pending_load)
              pending_load <= 1'b0;
            else
              tx_sr <= {tx_sr[W-2:0], 1'b1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso    = busy ? tx_sr[W-1] : 1'b1;
  assign spi_miso_oe = busy;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a bit-banged SPI master with a transaction-level model of the
// TX buffer / RX register, a per-cycle compare process and literal spot checks.
`timescale 1ns/1ps
module tb_spi_slave_core;
  localparam int W = 8, SYNC = 2, H = 8, CLK_P = 10;

  logic clk = 1'b0, reset = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, tx_wr = 1'b0, rx_rd = 1'b0, clr_err = 1'b0;
  logic [W-1:0] tx_data = '0, rx_data;
  logic tx_full, rx_avail, rx_overrun, tx_underrun, busy, spi_miso, spi_miso_oe;
  logic spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;

  always #(CLK_P/2) clk = ~clk;

  spi_slave_core #(.W(W), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_avail(rx_avail),
    .clr_err(clr_err), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model of the local-side registers.
  logic [W-1:0] m_rx_data;
  bit           m_rx_avail, m_ovr, m_udr;
  logic [W-1:0] m_txq[$];

  function automatic void m_reset();
    m_rx_data = '0; m_rx_avail = 0; m_ovr = 0; m_udr = 0; m_txq.delete();
  endfunction

  function automatic logic [W-1:0] m_load();
    if (m_txq.size() > 0) return m_txq.pop_front();
    m_udr = 1;
    return '1;
  endfunction

  function automatic void m_write(input logic [W-1:0] d);
    if (m_txq.size() == 0) m_txq.push_back(d);
  endfunction

  function automatic void m_complete(input logic [W-1:0] d, input bit rd);
    if (m_rx_avail && !rd) m_ovr = 1;
    m_rx_data  = d;
    m_rx_avail = 1;
  endfunction

  // phase 0: not compared, 1: settled idle, 2: inside a transfer
  int   phase = 0;
  time  last_shift_t = 0;
  logic prev_miso = 1'b1;

  always @(negedge clk) begin
    if (phase == 1) begin
      check("idle_rx_data", rx_data, m_rx_data);
      check("idle_rx_avail", rx_avail, m_rx_avail);
      check("idle_overrun", rx_overrun, m_ovr);
      check("idle_underrun", tx_underrun, m_udr);
      check("idle_tx_full", tx_full, m_txq.size() != 0);
      check("idle_busy", busy, 0);
      check("idle_oe", spi_miso_oe, 0);
      check("idle_miso", spi_miso, 1);
    end else if (phase == 2) begin
      check("act_busy", busy, 1);
      check("act_oe", spi_miso_oe, 1);
      if (spi_miso !== prev_miso)
        check("miso_on_shift_edge", ($time - last_shift_t) <= (SYNC + 3) * CLK_P, 1);
    end
    prev_miso = spi_miso;
  end

  // Per-frame stimulus controls for xfer().
  logic [W-1:0] f_mosi[4], f_wrd[4], f_refd[4], got[4], exp_got[4];
  bit           f_rd[4], f_wrc[4], f_refill[4];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_frames();
    for (int i = 0; i < 4; i++) begin
      f_rd[i] = 0; f_wrc[i] = 0; f_refill[i] = 0;
    end
  endtask

  // One SCLK half period; optional strobes land on the cycle the DUT acts on the edge just driven.
  task automatic half_period(input bit rdp, input bit wrp, input logic [W-1:0] wd,
                             input bit refp, input logic [W-1:0] refd);
    for (int j = 1; j <= H; j++) begin
      @(negedge clk);
      if (j == SYNC) begin
        if (rdp) rx_rd = 1'b1;
        if (wrp) begin tx_wr = 1'b1; tx_data = wd; end
      end else if (j == SYNC + 1) begin
        rx_rd = 1'b0; tx_wr = 1'b0;
      end else if (j == SYNC + 3 && refp) begin
        tx_wr = 1'b1; tx_data = refd;
      end else if (j == SYNC + 4) begin
        tx_wr = 1'b0;
      end
    end
  endtask

  // Master transfer of nf frames; the last frame carries last_bits sample edges.
  // In cpha=0 the final trailing edge is issued after SS_n rises.
  task automatic xfer(input int nf, input int last_bits);
    int ne, b;
    bit smp, rdp, wrp, refp;
    logic [W-1:0] wd, refd;
    phase = 0;
    spi_ss_n = 1'b0;
    spi_mosi = cpha ? 1'b0 : f_mosi[0][W-1];
    last_shift_t = $time;
    if (!cpha) exp_got[0] = m_load();
    tick(H);
    phase = 2;
    for (int f = 0; f < nf; f++) begin
      ne = (f == nf - 1) ? (cpha ? 2 * last_bits : 2 * last_bits - 1) : 2 * W;
      for (int e = 0; e < ne; e++) begin
        smp = cpha ? e[0] : !e[0];
        b = W - 1 - e / 2;
        rdp = 0; wrp = 0; refp = 0; wd = '0; refd = '0;
        if (smp) begin
          got[f][b] = spi_miso;
          if (b == 0) begin
            m_complete(f_mosi[f], f_rd[f]);
            rdp = f_rd[f];
          end
          if (b == W / 2 && f_refill[f]) begin
            refp = 1; refd = f_refd[f];
            m_write(refd);
          end
        end else begin
          last_shift_t = $time;
          if (cpha) begin
            if (e == 0) begin
              exp_got[f] = m_load();
              if (f > 0) begin
                wrp = f_wrc[f-1]; wd = f_wrd[f-1];
                if (wrp) m_write(wd);
              end
            end
            spi_mosi = f_mosi[f][b];
          end else if (b > 0) begin
            spi_mosi = f_mosi[f][b-1];
          end else begin
            spi_mosi = f_mosi[f+1][W-1];
            exp_got[f+1] = m_load();
            wrp = f_wrc[f]; wd = f_wrd[f];
            if (wrp) m_write(wd);
          end
        end
        spi_sclk = ~spi_sclk;
        half_period(rdp, wrp, wd, refp, refd);
      end
    end
    phase = 0;
    spi_ss_n = 1'b1;
    tick(SYNC + 2);
    spi_sclk = cpol;
    tick(SYNC + 4);
    phase = 1;
  endtask

  task automatic do_rd();
    phase = 0; rx_rd = 1'b1; m_rx_avail = 0;
    tick(1); rx_rd = 1'b0; tick(2); phase = 1;
  endtask

  task automatic do_wr(input logic [W-1:0] d);
    phase = 0; tx_wr = 1'b1; tx_data = d; m_write(d);
    tick(1); tx_wr = 1'b0; tick(2); phase = 1;
  endtask

  task automatic do_clr();
    phase = 0; clr_err = 1'b1; m_ovr = 0; m_udr = 0;
    tick(1); clr_err = 1'b0; tick(2); phase = 1;
  endtask

  task automatic set_mode(input bit p, input bit h);
    phase = 0; cpol = p; cpha = h; spi_sclk = p;
    tick(SYNC + 4); phase = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_reset();
    clear_frames();
    tick(3);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_avail", rx_avail, 0);
    check("rst_flags", {rx_overrun, tx_underrun}, 0);
    check("rst_busy_oe", {busy, spi_miso_oe}, 0);
    check("rst_miso", spi_miso, 1);
    reset = 1'b0;
    tick(2);
    phase = 1;

    // Mode 0 single exchange.
    do_wr(8'hA5);
    f_mosi[0] = 8'h3C;
    xfer(1, W);
    check("m0_got_model", got[0], exp_got[0]);
    check("m0_got", got[0], 8'hA5);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_status", {rx_avail, tx_full, rx_overrun, tx_underrun}, 4'b1000);

    // Modes 1..3, same exchange.
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      do_rd();
      do_wr(8'hA5);
      clear_frames();
      f_mosi[0] = 8'h3C;
      xfer(1, W);
      check($sformatf("mode%0d_got", m), got[0], 8'hA5);
      check($sformatf("mode%0d_rx_data", m), rx_data, 8'h3C);
      check($sformatf("mode%0d_status", m), {rx_avail, tx_full, rx_overrun, tx_underrun}, 4'b1000);
    end

    // Three back-to-back frames, buffer refilled only once.
    set_mode(0, 0);
    do_rd();
    do_clr();
    do_wr(8'h11);
    clear_frames();
    f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
    f_refill[0] = 1; f_refd[0] = 8'h22;
    xfer(3, W);
    for (int f = 0; f < 3; f++) check($sformatf("b2b_got%0d_model", f), got[f], exp_got[f]);
    check("b2b_got0", got[0], 8'h11);
    check("b2b_got1", got[1], 8'h22);
    check("b2b_got2", got[2], 8'hFF);
    check("b2b_rx_data", rx_data, 8'h03);
    check("b2b_flags", {rx_overrun, tx_underrun}, 2'b11);

    // Partial frame of 5 bits, then a full frame.
    do_rd();
    do_clr();
    do_wr(8'h77);
    clear_frames();
    f_mosi[0] = 8'hFF;
    xfer(1, 5);
    check("part_rx_avail", rx_avail, 0);
    check("part_busy", busy, 0);
    check("part_flags", {rx_overrun, tx_underrun}, 0);
    do_wr(8'h88);
    f_mosi[0] = 8'h5A;
    xfer(1, W);
    check("after_part_rx_data", rx_data, 8'h5A);
    check("after_part_got", got[0], 8'h88);
    check("after_part_status", {rx_avail, rx_overrun, tx_underrun}, 3'b100);

    // rx_rd coincident with completion; tx_wr coincident with a TX load.
    do_wr(8'h31);
    clear_frames();
    f_mosi[0] = 8'h44; f_mosi[1] = 8'h55;
    f_refill[0] = 1; f_refd[0] = 8'h32;
    f_wrc[0] = 1; f_wrd[0] = 8'h33;
    f_rd[0] = 1; f_rd[1] = 1;
    xfer(2, W);
    check("coin_got0", got[0], 8'h31);
    check("coin_got1", got[1], 8'h32);
    check("coin_rx_data", rx_data, 8'h55);
    check("coin_status", {rx_avail, rx_overrun, tx_full}, 3'b101);
    do_rd();
    clear_frames();
    f_mosi[0] = 8'h66;
    xfer(1, W);
    check("coin_retained", got[0], 8'h33);
    check("coin_after", {tx_full, tx_underrun}, 0);

    // Asynchronous reset in the middle of a frame.
    do_wr(8'h99);
    phase = 0;
    spi_ss_n = 1'b0; spi_mosi = 1'b1;
    tick(H);
    spi_sclk = 1'b1;
    tick(H);
    spi_sclk = 1'b0;
    tick(SYNC);
    tx_wr = 1'b1; tx_data = 8'hAB;
    tick(1);
    tx_wr = 1'b0;
    tick(H);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_avail_full", {rx_avail, tx_full}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx_full", tx_full, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_avail", rx_avail, 0);
    check("midrst_flags", {rx_overrun, tx_underrun}, 0);
    check("midrst_busy_oe", {busy, spi_miso_oe}, 0);
    check("midrst_miso", spi_miso, 1);
    tick(3);
    spi_ss_n = 1'b1; spi_sclk = 1'b0;
    tick(SYNC + 2);
    reset = 1'b0;
    m_reset();
    tick(2);
    phase = 1;
    do_wr(8'hE7);
    clear_frames();
    f_mosi[0] = 8'hC3;
    xfer(1, W);
    check("post_rst_rx_data", rx_data, 8'hC3);
    check("post_rst_got", got[0], 8'hE7);
    check("post_rst_status", {rx_avail, rx_overrun, tx_underrun}, 3'b100);

    phase = 0;
    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
